// File: rtl/udma_rx_sink_channel_pkg.sv
// udma_rx_sink_pkg: shared types and helpers for the uDMA RX sink channel
package udma_rx_sink_pkg;

    localparam int RX_AWIDTH = 19;
    localparam int RX_TSIZE  = 20;

    typedef enum logic {IDLE, ACTIVE} rx_state_e;

    typedef enum logic [1:0] {DS_BYTE = 2'd0, DS_HALF = 2'd1, DS_WORD = 2'd2} datasize_e;

    typedef struct packed {
        logic [RX_AWIDTH-1:0] startaddr;
        logic [RX_TSIZE-1:0]  size;
        logic [1:0]           datasize;
        logic                 continuous;
    } rx_desc_t;

    function automatic logic [2:0] step_bytes(input logic [1:0] datasize);
        return datasize == DS_BYTE ? 3'd1 : datasize == DS_HALF ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/udma_rx_sink_channel_if.sv
// udma_rx_sink_channel_if: UART RX beat stream from udma_uart_top into the RX sink channel
interface udma_rx_sink_channel_if;

    logic [1:0]  datasize;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output datasize, data, valid, input ready);
    modport slave  (input datasize, data, valid, output ready);

endinterface

// File: rtl/udma_rx_sink_channel_byte_mem.sv
// udma_rx_byte_mem: byte-enabled write port with wrapping lanes and combinational aligned word read
module udma_rx_byte_mem #(
    parameter  int MEM_BYTES = 1024,
    localparam int MW        = $clog2(MEM_BYTES)
) (
    input  logic          sys_clk_i,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [MW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [MW-3:0] rd_word,
    output logic [31:0]   rd_data
);

    logic [7:0] mem [MEM_BYTES];

    // each enabled lane lands at wr_addr+lane, wrapping modulo MEM_BYTES
    always_ff @(posedge sys_clk_i)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[wr_addr + MW'(i)] <= wr_data[8*i +: 8];

    assign rd_data = {mem[{rd_word, 2'd3}], mem[{rd_word, 2'd2}], mem[{rd_word, 2'd1}], mem[{rd_word, 2'd0}]};

endmodule

// File: rtl/udma_rx_sink_channel.sv
// udma_rx_sink_channel: uDMA RX channel storing UART RX beats in local memory; RX_SINK_BEAT_CNT_EN adds beat_cnt_o
module udma_rx_sink_channel
    import udma_rx_sink_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = RX_AWIDTH,
    parameter int TRANS_SIZE     = RX_TSIZE,
    parameter int MEM_BYTES      = 1024
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_rx_size_i,
    input  logic [1:0]                cfg_rx_datasize_i,
    input  logic                      cfg_rx_continuous_i,
    input  logic                      cfg_rx_en_i,
    input  logic                      cfg_rx_clr_i,
    output logic                      cfg_rx_en_o,
    output logic                      cfg_rx_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_o,
    udma_rx_sink_channel_if.slave     rx,
    output logic                      eot_event_o,
    input  logic [L2_AWIDTH_NOAL-1:0] rd_addr_i,
    output logic [31:0]               rd_data_o
`ifdef RX_SINK_BEAT_CNT_EN
   ,output logic [15:0]               beat_cnt_o
`endif
);

    localparam int MW = $clog2(MEM_BYTES);
    localparam logic [0:0] S_IDLE   = IDLE;
    localparam logic [0:0] S_ACTIVE = ACTIVE;

    logic [0:0]                state;
    rx_desc_t                  cur, pend, in_desc, nxt;
    logic                      pend_v, en_q, eot;
    logic [L2_AWIDTH_NOAL-1:0] curr_addr;
    logic [TRANS_SIZE-1:0]     bytes_left, left_dec;
    logic [2:0]                step;
    logic                      accept, done, load_ok, rise, unused_bits;

    assign in_desc  = '{startaddr: RX_AWIDTH'(cfg_rx_startaddr_i), size: RX_TSIZE'(cfg_rx_size_i),
                        datasize: cfg_rx_datasize_i, continuous: cfg_rx_continuous_i};
    assign step     = step_bytes(cur.datasize);
    assign left_dec = bytes_left > TRANS_SIZE'(step) ? bytes_left - TRANS_SIZE'(step) : '0;
    assign rx.ready = state == S_ACTIVE && !cfg_rx_clr_i;
    assign accept   = rx.valid && rx.ready;
    assign done     = accept && left_dec == '0;
    assign load_ok  = cfg_rx_en_i && cfg_rx_size_i != '0;
    assign rise     = load_ok && !en_q;
    assign nxt      = pend_v ? pend : rise ? in_desc : cur;

    assign cfg_rx_en_o         = state == S_ACTIVE;
    assign cfg_rx_pending_o    = pend_v;
    assign cfg_rx_curr_addr_o  = curr_addr;
    assign cfg_rx_bytes_left_o = bytes_left;
    assign eot_event_o         = eot;
    assign unused_bits         = ^{rx.datasize, rd_addr_i[1:0], rd_addr_i[L2_AWIDTH_NOAL-1:MW]};

    // channel sequencing: clear wins, then start from idle, then accept/reload/queue while active
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            cur        <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            en_q       <= 1'b0;
            eot        <= 1'b0;
            curr_addr  <= '0;
            bytes_left <= '0;
        end else begin
            en_q <= cfg_rx_en_i;
            eot  <= 1'b0;
            if (cfg_rx_clr_i) begin
                state      <= S_IDLE;
                pend_v     <= 1'b0;
                curr_addr  <= '0;
                bytes_left <= '0;
            end else if (state == S_IDLE) begin
                if (load_ok) begin
                    state      <= S_ACTIVE;
                    cur        <= in_desc;
                    curr_addr  <= L2_AWIDTH_NOAL'(in_desc.startaddr);
                    bytes_left <= TRANS_SIZE'(in_desc.size);
                end
            end else if (done) begin
                eot <= 1'b1;
                if (pend_v || rise || cur.continuous) begin
                    cur        <= nxt;
                    pend_v     <= 1'b0;
                    curr_addr  <= L2_AWIDTH_NOAL'(nxt.startaddr);
                    bytes_left <= TRANS_SIZE'(nxt.size);
                end else begin
                    state      <= S_IDLE;
                    curr_addr  <= curr_addr + L2_AWIDTH_NOAL'(step);
                    bytes_left <= '0;
                end
            end else begin
                if (rise && !pend_v) begin
                    pend   <= in_desc;
                    pend_v <= 1'b1;
                end
                if (accept) begin
                    curr_addr  <= curr_addr + L2_AWIDTH_NOAL'(step);
                    bytes_left <= left_dec;
                end
            end
        end
    end

`ifdef RX_SINK_BEAT_CNT_EN
    // accepted-beat counter, wrapping at 16 bits
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) beat_cnt_o <= '0;
        else if (cfg_rx_clr_i) beat_cnt_o <= '0;
        else if (accept) beat_cnt_o <= beat_cnt_o + 16'd1;
    end
`endif

    udma_rx_byte_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
        .sys_clk_i (sys_clk_i),
        .we        (accept),
        .be        ({{2{step[2]}}, step[2] | step[1], 1'b1}),
        .wr_addr   (curr_addr[MW-1:0]),
        .wr_data   (rx.data),
        .rd_word   (rd_addr_i[MW-1:2]),
        .rd_data   (rd_data_o)
    );

endmodule

// File: tb/tb_udma_rx_sink_channel.sv
// tb_udma_rx_sink_channel: scoreboard bench for the uDMA RX sink channel
module tb_udma_rx_sink_channel;

    typedef struct {
        string       name;
        bit          en, rdy, pend;
        logic [31:0] addr, left;
        bit          do_rd;
        logic [31:0] rd_d;
    } exp_t;

    logic        clk = 0, rstn = 0;
    logic [18:0] sa = '0, rd_addr = '0, curr_addr;
    logic [19:0] sz = '0, left;
    logic [1:0]  dsz = '0;
    logic        cont = 0, en = 0, clr = 0, snp = 0;
    logic        en_o, pend_o, eot;
    logic [31:0] rd_data;
    int          checks = 0, failures = 0;
    exp_t        eot_q[$], stat_q[$];
    exp_t        e_mon;

    udma_rx_sink_channel_if rx_if();

`ifdef RX_SINK_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    udma_rx_sink_channel dut (
        .sys_clk_i           (clk),
        .rstn_i              (rstn),
        .cfg_rx_startaddr_i  (sa),
        .cfg_rx_size_i       (sz),
        .cfg_rx_datasize_i   (dsz),
        .cfg_rx_continuous_i (cont),
        .cfg_rx_en_i         (en),
        .cfg_rx_clr_i        (clr),
        .cfg_rx_en_o         (en_o),
        .cfg_rx_pending_o    (pend_o),
        .cfg_rx_curr_addr_o  (curr_addr),
        .cfg_rx_bytes_left_o (left),
        .rx                  (rx_if.slave),
        .eot_event_o         (eot),
        .rd_addr_i           (rd_addr),
        .rd_data_o           (rd_data)
`ifdef RX_SINK_BEAT_CNT_EN
       ,.beat_cnt_o          (beat_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endfunction

    function automatic void cmp(exp_t e);
        chk({e.name, ".en"}, 32'(en_o), 32'(e.en));
        chk({e.name, ".ready"}, 32'(rx_if.ready), 32'(e.rdy));
        chk({e.name, ".pending"}, 32'(pend_o), 32'(e.pend));
        chk({e.name, ".curr_addr"}, 32'(curr_addr), e.addr);
        chk({e.name, ".bytes_left"}, 32'(left), e.left);
        if (e.do_rd) chk({e.name, ".rd_data"}, rd_data, e.rd_d);
    endfunction

    initial forever begin
        @(negedge clk);
        if (eot) begin
            if (eot_q.size() == 0) chk("eot_unexpected", 32'd1, 32'd0);
            else begin
                e_mon = eot_q.pop_front();
                cmp(e_mon);
            end
        end
        if (snp) begin
            if (stat_q.size() == 0) chk("snap_underflow", 32'd1, 32'd0);
            else begin
                e_mon = stat_q.pop_front();
                cmp(e_mon);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [18:0] a, input logic [19:0] s, input logic [1:0] d, input logic c);
        sa = a; sz = s; dsz = d; cont = c; en = 1;
        tick();
        en = 0;
        tick();
    endtask

    task automatic beat(input logic [31:0] d);
        rx_if.valid = 1; rx_if.data = d;
        tick();
        rx_if.valid = 0;
    endtask

    task automatic clear();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic expect_eot(input string n, input bit e, input bit r, input bit p, input logic [31:0] a, input logic [31:0] l);
        eot_q.push_back('{n, e, r, p, a, l, 1'b0, 32'd0});
    endtask

    task automatic snap(input string n, input bit e, input bit r, input bit p, input logic [31:0] a,
                        input logic [31:0] l, input bit dr, input logic [31:0] ra, input logic [31:0] rd);
        stat_q.push_back('{n, e, r, p, a, l, dr, rd});
        rd_addr = ra[18:0];
        snp = 1;
        @(negedge clk);
        #1;
        snp = 0;
    endtask

    initial begin
        rx_if.valid = 0; rx_if.data = '0; rx_if.datasize = '0;
        repeat (3) tick();
        snap("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1;
        tick();

        start(19'h934, 20'h50, 2'd0, 0);
        for (int i = 0; i < 20; i++) beat(i % 2 ? 32'h56 : 32'h15);
        snap("byte", 1, 1, 0, 32'h948, 32'h3C, 1, 32'h934, 32'h56155615);
        clear();
        snap("clr_byte", 0, 0, 0, 0, 0, 1, 32'h944, 32'h56155615);

        start(19'h10, 20'd4, 2'd0, 0);
        expect_eot("done", 0, 0, 0, 32'h14, 0);
        for (int i = 1; i <= 4; i++) beat(32'(i));
        snap("done_rd", 0, 0, 0, 32'h14, 0, 1, 32'h10, 32'h04030201);

        start(19'h40, 20'd8, 2'd2, 1);
        expect_eot("cont", 1, 1, 0, 32'h40, 32'd8);
        beat(32'hAABBCCDD);
        beat(32'h11223344);
        beat(32'h55667788);
        snap("cont3", 1, 1, 0, 32'h44, 32'd4, 1, 32'h40, 32'h55667788);
        snap("cont4", 1, 1, 0, 32'h44, 32'd4, 1, 32'h44, 32'h11223344);
        clear();

        start(19'h80, 20'd2, 2'd0, 0);
        start(19'h100, 20'd3, 2'd0, 0);
        snap("pend_set", 1, 1, 1, 32'h80, 32'd2, 0, 0, 0);
        expect_eot("pend_load", 1, 1, 0, 32'h100, 32'd3);
        beat(32'h01);
        beat(32'h02);
        expect_eot("pend_done", 0, 0, 0, 32'h103, 0);
        for (int i = 0; i < 3; i++) beat(32'h30 + 32'(i));

        start(19'h180, 20'd1, 2'd0, 0);
        expect_eot("simul", 1, 1, 0, 32'h1C0, 32'd2);
        sa = 19'h1C0; sz = 20'd2; en = 1; rx_if.valid = 1; rx_if.data = 32'h5A;
        tick();
        en = 0; rx_if.valid = 0;
        expect_eot("simul_done", 0, 0, 0, 32'h1C2, 0);
        beat(32'h61);
        beat(32'h62);
        snap("simul_pend", 0, 0, 0, 32'h1C2, 0, 0, 0, 0);

        start(19'h934, 20'h10, 2'd0, 0);
        beat(32'h15);
        beat(32'h56);
        start(19'h200, 20'd4, 2'd0, 0);
        snap("clr_pend", 1, 1, 1, 32'h936, 32'h0E, 0, 0, 0);
        clr = 1; rx_if.valid = 1; rx_if.data = 32'hEE;
        tick();
        clr = 0; rx_if.valid = 0;
        snap("clr_mid", 0, 0, 0, 0, 0, 1, 32'h934, 32'h56155615);

        start(19'h300, 20'd3, 2'd1, 0);
        expect_eot("sat", 0, 0, 0, 32'h304, 0);
        beat(32'hDEAD2211);
        snap("sat1", 1, 1, 0, 32'h302, 32'd1, 0, 0, 0);
        beat(32'hBEEF4433);
        snap("sat_rd", 0, 0, 0, 32'h304, 0, 1, 32'h300, 32'h44332211);

        start(19'h3FC, 20'd8, 2'd2, 0);
        expect_eot("wrap_w", 0, 0, 0, 32'h404, 0);
        beat(32'h44332211);
        beat(32'h88776655);
        start(19'h3FF, 20'd2, 2'd1, 0);
        expect_eot("wrap_h", 0, 0, 0, 32'h401, 0);
        beat(32'h0000BBAA);
        snap("wrap_hi", 0, 0, 0, 32'h401, 0, 1, 32'h3FC, 32'hAA332211);
        snap("wrap_lo", 0, 0, 0, 32'h401, 0, 1, 32'h0, 32'h887766BB);

        repeat (3) tick();
        chk("eot_q_drain", 32'(eot_q.size()), 32'd0);
        chk("stat_q_drain", 32'(stat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
